// File: rtl/pc_ctrl_pkg.sv
// Shared constants, state type and control-class helper for the PC redirect controller.
package pc_ctrl_pkg;

  localparam logic [6:0]  OP_JAL           = 7'b1101111;
  localparam logic [6:0]  OP_JALR          = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH        = 7'b1100011;

  localparam logic [31:0] INST_ECALL       = 32'h0000_0073;
  localparam logic [31:0] INST_CSR_CYCLE   = 32'hc000_1073;
  localparam logic [31:0] INST_MRET        = 32'h3020_0073;
  localparam logic [31:0] INST_SRET        = 32'h1020_0073;

  localparam int unsigned WAIT_MAX_DEFAULT = 7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // System encodings that stall fetch even though their opcode is not a branch/jump.
  function automatic logic is_special_inst(input logic [31:0] inst);
    logic hit;
    hit = (inst == INST_ECALL) || (inst == INST_CSR_CYCLE) ||
          (inst == INST_MRET)  || (inst == INST_SRET);
    return hit;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational classifier: flags instructions whose successor PC is unknown at fetch.
module ctl_decode
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] if_inst,
  output logic        is_ctl
);

  // Opcode match for branches/jumps, full-word match for the system encodings.
  always_comb begin
    is_ctl = 1'b0;
    case (if_inst[6:0])
      OP_JAL, OP_JALR, OP_BRANCH: is_ctl = 1'b1;
      default:                    is_ctl = is_special_inst(if_inst);
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC sequencing and redirect control: holds fetch on control-class instructions
// until EX resolves, a trap/xret arrives, or the wait window expires.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        ex_resolve_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        xret_req,
  input  logic [31:0] xret_target,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        if_flush,
  output logic        busy,
  output logic        ctl_timeout
);

  localparam int unsigned     CNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  state_e           state_r;
  state_e           state_nx_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_nx_s;
  logic             is_ctl_s;
  logic [31:0]      seq_pc_s;

  assign seq_pc_s = if_pc + 32'd4;

  ctl_decode u_ctl_decode (
    .if_inst (if_inst),
    .is_ctl  (is_ctl_s)
  );

  // Next-state and Mealy outputs; reset overrides everything combinationally.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    next_pc       = seq_pc_s;
    pc_write      = 1'b0;
    if_flush      = 1'b0;
    busy          = 1'b0;
    ctl_timeout   = 1'b0;
    if (rst) begin
      next_pc       = RESET_PC;
      pc_write      = 1'b1;
      if_flush      = 1'b1;
      state_nx_s    = ST_RUN;
      wait_cnt_nx_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          wait_cnt_nx_s = '0;
          if (trap_req) begin
            next_pc  = trap_vec;
            pc_write = 1'b1;
          end else if (xret_req) begin
            next_pc  = xret_target;
            pc_write = 1'b1;
          end else if (stall) begin
            pc_write = 1'b0;
          end else if (is_ctl_s) begin
            state_nx_s = ST_WAIT;
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_WAIT: begin
          if_flush      = 1'b1;
          busy          = 1'b1;
          wait_cnt_nx_s = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + CNT_W'(1);
          if (trap_req) begin
            next_pc    = trap_vec;
            pc_write   = 1'b1;
            state_nx_s = ST_RUN;
          end else if (xret_req) begin
            next_pc    = xret_target;
            pc_write   = 1'b1;
            state_nx_s = ST_RUN;
          end else if (ex_resolve_valid) begin
            next_pc    = ex_taken ? ex_target : seq_pc_s;
            pc_write   = 1'b1;
            state_nx_s = ST_RUN;
          end else if (wait_cnt_r == CNT_MAX) begin
            next_pc     = trap_vec;
            pc_write    = 1'b1;
            ctl_timeout = 1'b1;
            state_nx_s  = ST_RUN;
          end else begin
            pc_write = 1'b0;
          end
        end
        default: begin
          state_nx_s    = ST_RUN;
          wait_cnt_nx_s = '0;
        end
      endcase
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the redirect rules.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          WMAX   = 7;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] JAL   = 32'h0000_006f;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst, if_pc, ex_target, trap_vec, xret_target;
  logic        stall, ex_resolve_valid, ex_taken, trap_req, xret_req;
  logic [31:0] next_pc;
  logic        pc_write, if_flush, busy, ctl_timeout;

  int total = 0;
  int bad   = 0;

  // reference model: are we waiting for a resolve, and how many wait cycles have elapsed
  bit m_wait = 1'b0;
  int m_cnt  = 0;
  bit n_wait;
  int n_cnt;

  logic [31:0] pool [10] = '{32'h0000_0013, 32'h00a0_0093, 32'hfe20_8ee3, 32'h0080_006f,
                             32'h0000_8067, 32'h0000_0073, 32'hc000_1073, 32'h3020_0073,
                             32'h1020_0073, 32'h0010_0073};

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(RST_PC), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc), .stall(stall),
    .ex_resolve_valid(ex_resolve_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .trap_req(trap_req), .trap_vec(trap_vec), .xret_req(xret_req), .xret_target(xret_target),
    .next_pc(next_pc), .pc_write(pc_write), .if_flush(if_flush), .busy(busy),
    .ctl_timeout(ctl_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_is_ctl(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return (op == 7'h6f) || (op == 7'h67) || (op == 7'h63) ||
           (i inside {32'h0000_0073, 32'hc000_1073, 32'h3020_0073, 32'h1020_0073});
  endfunction

  // Sample outputs mid-cycle and compare with the rule-based expectation.
  task automatic sample();
    logic [31:0] e_pc;
    bit e_wr, e_to;
    @(negedge clk);
    e_pc = if_pc + 32'd4; e_wr = 1'b0; e_to = 1'b0;
    n_wait = m_wait; n_cnt = m_cnt;
    if (rst) begin
      e_wr = 1'b1; e_pc = RST_PC; n_wait = 1'b0; n_cnt = 0;
    end else if (trap_req) begin
      e_wr = 1'b1; e_pc = trap_vec; n_wait = 1'b0;
    end else if (xret_req) begin
      e_wr = 1'b1; e_pc = xret_target; n_wait = 1'b0;
    end else if (m_wait && ex_resolve_valid) begin
      e_wr = 1'b1; e_pc = ex_taken ? ex_target : if_pc + 32'd4; n_wait = 1'b0;
    end else if (m_wait && m_cnt >= WMAX) begin
      e_wr = 1'b1; e_pc = trap_vec; e_to = 1'b1; n_wait = 1'b0;
    end else if (m_wait) begin
      n_cnt = m_cnt + 1;
    end else if (stall) begin
      e_wr = 1'b0;
    end else if (ref_is_ctl(if_inst)) begin
      n_wait = 1'b1; n_cnt = 0;
    end else begin
      e_wr = 1'b1;
    end
    chk("m_pc_write", 32'(pc_write), 32'(e_wr));
    if (e_wr) chk("m_next_pc", next_pc, e_pc);
    chk("m_if_flush", 32'(if_flush), 32'(rst || m_wait));
    chk("m_busy", 32'(busy), 32'(!rst && m_wait));
    chk("m_timeout", 32'(ctl_timeout), 32'(e_to));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    m_wait = n_wait;
    m_cnt  = n_cnt;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; ex_resolve_valid = 1'b0; ex_taken = 1'b0;
    trap_req = 1'b0; xret_req = 1'b0; if_inst = NOP;
    ex_target = 32'h0; trap_vec = 32'h8000; xret_target = 32'h300;
  endtask

  int waits, pulses;
  bit done;
  logic [31:0] got_pc;

  initial begin
    idle();
    if_pc = 32'h100;
    rst = 1'b1;
    sample();
    chk("rst_next_pc", next_pc, RST_PC);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_flush", 32'(if_flush), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    adv(); sample(); adv();
    rst = 1'b0;

    // sequential and stall
    if_pc = 32'h100; if_inst = NOP;
    sample(); chk("seq_pc", next_pc, 32'h104); chk("seq_wr", 32'(pc_write), 32'd1); adv();
    stall = 1'b1; if_inst = BEQ;
    sample(); chk("stall_wr", 32'(pc_write), 32'd0); adv();
    stall = 1'b0;

    // branch taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      if_pc = 32'h200; if_inst = BEQ;
      sample(); chk("br_hold", 32'(pc_write), 32'd0); adv();
      if_inst = NOP;
      for (int k = 0; k < 2; k++) begin
        sample(); chk("br_flush", 32'(if_flush), 32'd1); adv();
      end
      ex_resolve_valid = 1'b1; ex_taken = t[0]; ex_target = 32'h80;
      sample();
      chk("br_pc", next_pc, (t == 1) ? 32'h80 : 32'h204);
      chk("br_wr", 32'(pc_write), 32'd1);
      adv();
      ex_resolve_valid = 1'b0;
      sample(); chk("br_run", 32'(busy), 32'd0); adv();
    end

    // trap beats xret in WAIT
    if_inst = ECALL; sample(); adv();
    if_inst = NOP; trap_req = 1'b1; xret_req = 1'b1;
    sample(); chk("prio_pc", next_pc, 32'h8000); adv();
    trap_req = 1'b0; xret_req = 1'b0;

    // timeout
    if_pc = 32'h300; if_inst = JAL; sample(); adv();
    if_inst = NOP; waits = 0; pulses = 0; done = 1'b0; got_pc = 32'h0;
    for (int k = 0; k < 20 && !done; k++) begin
      sample();
      if (ctl_timeout) pulses++;
      if (pc_write) begin done = 1'b1; got_pc = next_pc; end
      else waits++;
      adv();
    end
    sample(); if (ctl_timeout) pulses++; adv();
    chk("to_waits", 32'(waits), 32'd7);
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_pc", got_pc, 32'h8000);

    // reset in the middle of WAIT abandons the resolve
    if_pc = 32'h200; if_inst = BEQ; sample(); adv();
    if_inst = NOP; sample(); adv();
    rst = 1'b1; sample(); chk("mid_rst_pc", next_pc, RST_PC); adv();
    rst = 1'b0; ex_resolve_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h80;
    sample(); chk("mid_rst_busy", 32'(busy), 32'd0); chk("mid_rst_pc2", next_pc, 32'h204); adv();
    ex_resolve_valid = 1'b0;

    // wrap
    if_pc = 32'hffff_fffc; if_inst = NOP;
    sample(); chk("wrap_pc", next_pc, 32'h0); adv();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 59) == 0);
      stall            = ($urandom_range(0, 3) == 0);
      trap_req         = ($urandom_range(0, 19) == 0);
      xret_req         = ($urandom_range(0, 19) == 0);
      ex_resolve_valid = ($urandom_range(0, 7) == 0);
      ex_taken         = $urandom_range(0, 1) == 1;
      ex_target        = $urandom & 32'hffff_fffc;
      trap_vec         = $urandom & 32'hffff_fffc;
      xret_target      = $urandom & 32'hffff_fffc;
      if_pc            = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : ($urandom & 32'hffff_fffc);
      if_inst          = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 9)];
      sample();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the PC value after reset.
REQ-002 SHALL have parameter WAIT_MAX, default 7, the maximum number of cycles spent in WAIT before timeout.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port if_inst, input, 32, the instruction fetched this cycle.
REQ-006 SHALL have port if_pc, input, 32, the current PC register value.
REQ-007 SHALL have port stall, input, 1, load-use hazard hold.
REQ-008 SHALL have ports ex_resolve_valid (input, 1), ex_taken (input, 1) and ex_target (input, 32), the branch/jump resolution from EX.
REQ-009 SHALL have ports trap_req (input, 1) and trap_vec (input, 32), the trap entry request and stvec[31:0].
REQ-010 SHALL have ports xret_req (input, 1) and xret_target (input, 32), the mret/sret retire request and the mepc/sepc value.
REQ-011 SHALL have output next_pc, 32, the value the PC register loads.
REQ-012 SHALL have output pc_write, 1, the PC load enable.
REQ-013 SHALL have output if_flush, 1, which converts the IF/ID instruction to a nop.
REQ-014 SHALL have output busy, 1, asserted high while in WAIT.
REQ-015 SHALL have output ctl_timeout, 1, a one-cycle error pulse.

Function
REQ-016 SHALL classify if_inst as control-class when:
- opcode[6:0] is 1101111, 1100111 or 1100011; or
- the instruction equals 32'h00000073, 32'hc0001073, 32'h30200073 or 32'h10200073.
REQ-017 SHALL implement the FSM states RUN and WAIT; reset state is RUN.
REQ-018 In RUN with a non-control if_inst and stall=0, SHALL drive pc_write=1 and next_pc=if_pc+4, with 32-bit wrap (32'hfffffffc -> 0).
REQ-019 In RUN with stall=1 and no trap_req/xret_req, SHALL drive pc_write=0 and stay in RUN, even for a control-class if_inst.
REQ-020 In RUN with a control-class if_inst and stall=0, SHALL drive pc_write=0, go to WAIT, and clear wait_cnt.
REQ-021 In WAIT, SHALL drive if_flush=1 and busy=1, and increment wait_cnt each cycle.
REQ-022 SHALL resolve with the priority trap_req > xret_req > ex_resolve_valid > timeout; the first true term redirects.
REQ-023 Redirect targets SHALL be:
- trap_req: trap_vec;
- xret_req: xret_target;
- ex_resolve_valid with ex_taken=1: ex_target;
- ex_resolve_valid with ex_taken=0: if_pc+4.
REQ-024 On any redirect, SHALL drive pc_write=1 combinationally (same cycle), ignore stall, and return to RUN next cycle.
REQ-025 trap_req and xret_req SHALL redirect in RUN as well; if trap_req and xret_req are simultaneous, trap_req wins.
REQ-026 ex_resolve_valid in RUN SHALL be ignored.
REQ-027 When wait_cnt reaches WAIT_MAX with no resolve, SHALL:
- redirect to trap_vec;
- pulse ctl_timeout for exactly one cycle;
- return to RUN.
REQ-028 wait_cnt SHALL be width clog2(WAIT_MAX+1) and SHALL saturate; it never wraps.
REQ-029 next_pc, pc_write and if_flush SHALL be Mealy outputs; busy SHALL be decoded from state.

Reset
REQ-030 While rst=1, SHALL drive next_pc=RESET_PC, pc_write=1, if_flush=1, busy=0 and ctl_timeout=0.
REQ-031 While rst=1, state SHALL be RUN and wait_cnt=0.
REQ-032 rst asserted in WAIT SHALL abandon the pending resolve; no redirect from it occurs after rst releases.

Structure
REQ-033 pc_ctrl_pkg SHALL hold the opcode constants, the four special encodings, the state enum and the WAIT_MAX default.
REQ-034 SHALL instantiate one combinational sub-module ctl_decode (if_inst -> is_ctl) containing the REQ-016 classification.
REQ-035 SHALL have no other sub-modules; RTL target is under 250 lines.

Verification
REQ-036 Sequential run: if_pc=0x100, non-control if_inst, stall=0 -> next_pc=0x104, pc_write=1; with stall=1 -> pc_write=0.
REQ-037 Branch taken: beq at 0x200 -> WAIT with if_flush=1 for 2 cycles, then ex_resolve_valid=1, ex_taken=1, ex_target=0x80 -> next_pc=0x80, pc_write=1, RUN next cycle; with ex_taken=0 -> next_pc=0x204.
REQ-038 Trap/xret priority: if_inst=0x00000073 in WAIT, trap_req=1 with trap_vec=0x8000, xret_req=1 with xret_target=0x300 -> next_pc=0x8000.
REQ-039 Timeout: jal fetched, no resolve for 7 WAIT cycles, trap_vec=0x8000 -> next_pc=0x8000, ctl_timeout high exactly one cycle.
REQ-040 Reset mid-WAIT: rst=1 in WAIT cycle 2, then ex_resolve_valid=1 after release -> state RUN, next_pc=RESET_PC during reset, resolve ignored.
REQ-041 Wrap: if_pc=0xfffffffc, non-control if_inst -> next_pc=0x00000000.
